srt_div_ctrl: RTL

SRT_DIV_CTRL -- requirements
Module: srt_div_ctrl

---
 rtl/srt_div_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/srt_div_ctrl.sv
// srt_div_ctrl: sequencing controller for a radix-4 SRT single-precision divider with special-case bypass
module srt_div_ctrl #(
  parameter int ITERS = 13,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             dp_load,
  output logic             dp_iter,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             dp_post,
  input  logic [31:0]      quot_in,
  output logic             res_sign,
  output logic [9:0]       exp_diff,
  output logic             special,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result
);
  typedef enum logic [2:0] {IDLE, LOAD, ITER, POST, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
  state_t r_state, w_next;
  logic [31:0] r_a, r_b, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0] r_exp;
  logic r_sign, r_special;
  logic w_accept, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic w_nan, w_inf, w_zero, w_spec;
  logic [31:0] w_spec_res;
  // Denormals count as zero: only the exponent field decides zero-ness.
  assign w_a_zero   = r_a[30:23] == 8'h00;
  assign w_b_zero   = r_b[30:23] == 8'h00;
  assign w_a_inf    = &r_a[30:23] && r_a[22:0] == 23'd0;
  assign w_b_inf    = &r_b[30:23] && r_b[22:0] == 23'd0;
  assign w_a_nan    = &r_a[30:23] && |r_a[22:0];
  assign w_b_nan    = &r_b[30:23] && |r_b[22:0];
  assign w_nan      = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
  assign w_inf      = w_a_inf || w_b_zero;
  assign w_zero     = w_a_zero || w_b_inf;
  assign w_spec     = w_nan || w_inf || w_zero;
  assign w_spec_res = w_nan ? 32'h7FC00000 : w_inf ? {r_sign, 8'hFF, 23'd0} : {r_sign, 31'd0};
  assign w_accept   = in_valid && in_ready;
  assign iter_cnt   = r_cnt;
  assign result     = r_result;
  assign res_sign   = r_sign;
  assign exp_diff   = r_exp;
  assign special    = r_special;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Next-state and per-state strobes
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    dp_load   = 1'b0;
    dp_iter   = 1'b0;
    dp_post   = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        w_next   = in_valid ? LOAD : IDLE;
      end
      LOAD: begin
        dp_load = 1'b1;
        w_next  = w_spec ? DONE : ITER;
      end
      ITER: begin
        dp_iter = 1'b1;
        w_next  = r_cnt == LAST ? POST : ITER;
      end
      POST: begin
        dp_post = 1'b1;
        w_next  = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        w_next    = out_ready ? IDLE : DONE;
      end
      default: w_next = IDLE;
    endcase
  end
  // Operand capture, iteration counting and result capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_special <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_a       <= op_a;
        r_b       <= op_b;
        r_sign    <= op_a[31] ^ op_b[31];
        r_exp     <= {2'b00, op_a[30:23]} - {2'b00, op_b[30:23]} + 10'd127;
        r_special <= 1'b0;
      end
      if (dp_load) begin
        r_cnt <= '0;
        if (w_spec) begin
          r_result  <= w_spec_res;
          r_special <= 1'b1;
        end
      end
      if (dp_iter && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
      if (dp_post) r_result <= quot_in;
    end
endmodule
